// File: rtl/data_mem_sized.sv
// data_mem_sized
// Parametrised data memory for the CPU datapath, placed between EX/MEM and
// MEM/WB. It supports byte, half and word loads and stores, with sign or zero
// extension on loads. Misaligned, reserved-size and out-of-range requests are
// reported as faults. Requests use a valid/ready port, and each accepted
// request produces a registered one-cycle response. After reset, an optional
// hardware sweep clears the array, so the array itself has no reset.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   req_valid     request present
//   req_ready     block can accept a request this cycle
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 reserved (faults)
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   rsp_valid     one-cycle pulse, response for an accepted request
//   rsp_rdata     extended load result; 0 for stores and faults
//   rsp_fault     request faulted (qualified by rsp_valid)
//   busy          clear sweep in progress
module data_mem_sized #(
  parameter int DEPTH          = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments, so every flop
    // samples its pre-edge inputs and process ordering cannot matter.
    if (rst) begin
      state_q <= RESET_STATE;
      clr_idx <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy = 1'b1;
        if (clr_idx == LAST_IDX) state_d = S_IDLE;
      end
      S_IDLE: req_ready = 1'b1;
      default: state_d = RESET_STATE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_lane;
  logic             req_fault;
  logic             accept;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  assign req_idx  = req_addr[IDX_W+1:2];
  assign req_lane = req_addr[1:0];

  // Reset wins over a request. This matters when CLEAR_ON_RESET = 0, because
  // the block then sits in IDLE with req_ready high while reset is asserted.
  assign accept = req_valid && req_ready && !rst;

  always_comb begin
    req_fault = 1'b0;
    if (req_size == 2'b11)                           req_fault = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])          req_fault = 1'b1;
    if (req_size == SZ_WORD && req_lane != 2'b00)    req_fault = 1'b1;
    if ((req_addr >> (IDX_W + 2)) != 32'd0)          req_fault = 1'b1;
  end

  // Replicate the store data across all lanes. The byte enables then pick
  // the lanes that are actually written.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        wr_be   = 4'b0001 << req_lane;
        wr_data = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        wr_be   = req_lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      SZ_WORD: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset. Keeping the reset off it lets it map onto
  // plain RAM, and the clear sweep provides the zero contents instead.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR && !rst) begin
      mem[clr_idx] <= '0;
    end else if (accept && req_write && !req_fault) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[req_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request pipeline register (accept edge -> response edge)
  // ---------------------------------------------------------------------------
  logic             p_valid, p_write, p_unsigned, p_fault;
  logic [1:0]       p_size, p_lane;
  logic [IDX_W-1:0] p_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid    <= 1'b0;
      p_write    <= 1'b0;
      p_unsigned <= 1'b0;
      p_fault    <= 1'b0;
      p_size     <= SZ_BYTE;
      p_lane     <= 2'b00;
      p_idx      <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_write    <= req_write;
        p_unsigned <= req_unsigned;
        p_fault    <= req_fault;
        p_size     <= req_size;
        p_lane     <= req_lane;
        p_idx      <= req_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction
  // ---------------------------------------------------------------------------
  // The array is read at the response edge. A store accepted one cycle
  // earlier has therefore already committed, and its data is returned.
  logic [31:0] rd_word, ld_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_word = mem[p_idx];
  assign rd_byte = rd_word[{p_lane, 3'b000} +: 8];
  assign rd_half = rd_word[{p_lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = rd_word;
    case (p_size)
      SZ_BYTE: ld_data = {{24{rd_byte[7] & ~p_unsigned}}, rd_byte};
      SZ_HALF: ld_data = {{16{rd_half[15] & ~p_unsigned}}, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= p_valid;
      rsp_fault <= p_valid && p_fault;
      rsp_rdata <= (p_valid && !p_write && !p_fault) ? ld_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_data_mem_sized.sv
// tb_data_mem_sized
// Self-checking bench for data_mem_sized with DEPTH = 64 and CLEAR_ON_RESET = 1.
// The stimulus process updates a byte-array reference model whenever it
// issues a request, and pushes the expected response into a queue. A
// separate monitor pops that queue whenever rsp_valid is seen, and compares.
module tb_data_mem_sized;

  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  data_mem_sized #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  model_mem [NBYTES];
  int          total = 0;
  int          bad   = 0;
  int          pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory is a flat byte array, accesses are 1 << size bytes
  // little-endian, and anything outside [0, NBYTES) is a fault.
  task automatic model_req(input logic w, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output exp_t e);
    int n;
    logic [31:0] v;
    n = 1 << size;
    e.data  = 32'd0;
    e.fault = (size == 2'd3) || (addr % n != 0) || (addr >= NBYTES);
    if (!e.fault) begin
      if (w) begin
        for (int i = 0; i < n; i++) model_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(model_mem[addr + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        e.data = v;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
  endtask

  // Called at a negedge. This drives one request, which is accepted at the
  // next posedge, and returns at the following negedge. When use_lit is set,
  // the literal expectation is pushed instead of the model's.
  task automatic issue(input logic w, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic use_lit = 1'b0, input logic [31:0] lit_d = 0,
                       input logic lit_f = 1'b0);
    exp_t e;
    int   waited;
    waited = 0;
    while (!req_ready && waited < 200) begin
      req_valid = 1'b0;
      @(negedge clk);
      waited++;
    end
    if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    model_req(w, size, uns, addr, wdata, e);
    if (use_lit) begin
      e.data  = lit_d;
      e.fault = lit_f;
    end
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n = 1);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_fault"}, {31'd0, rsp_fault}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd1);
  endtask

  // Counts the cycles that busy stays high after reset release. Any request
  // driven during the sweep must be ignored, so the test holds a store on
  // the port for part of it.
  task automatic sweep_count(input string tag, input logic poke);
    int n;
    n = 0;
    if (poke) begin
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
      req_addr  = 32'h0; req_wdata = 32'hFFFF_FFFF;
    end
    while (busy && n < 200) begin
      if (req_ready) check({tag, "_ready_in_sweep"}, 32'd1, 32'd0);
      @(posedge clk); #1;
      n++;
      if (n == 40) req_valid = 1'b0;
    end
    check({tag, "_sweep_cycles"}, n, DEPTH);
    check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
  endtask

  // Monitor process
  always @(posedge clk) begin
    #1;
    if (rsp_valid) begin
      pulses++;
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.data);
        check("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.fault});
      end
    end
  end

  initial begin
    int p0;
    logic [1:0]  sz;
    logic [31:0] a;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    model_clear();

    // Power-on reset held for 2 cycles
    rst = 1'b1;
    @(negedge clk); check_reset_outputs("por");
    @(negedge clk);
    check({"por_ready"}, {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    sweep_count("por", 1'b1);

    // Cleared contents at both ends of the array
    issue(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0000_0000);
    issue(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 1'b1, 32'h0000_0000);
    idle();

    // Word store, byte overwrite, then word and byte loads
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11AA_3344);
    issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b1, 32'hFFFF_FFAA);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b1, 32'h0000_00AA);
    idle();

    // Half store to the upper lane, with its low half preserved
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h5555_1234);
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_8001);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b1, 32'hFFFF_8001);
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b1, 32'h0000_8001);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h8001_1234);
    idle();

    // Faults: all are stores, so a missing fault check would corrupt memory
    issue(1'b1, 2'b10, 1'b0, 32'h13,  32'hBAD0_0001, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 2'b01, 1'b0, 32'h21,  32'hBAD0_0002, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 32'h10,  32'hBAD0_0003, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hBAD0_0004, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h13,  32'h0,         1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h10,  32'h0, 1'b1, 32'h11AA_3344);
    issue(1'b0, 2'b10, 1'b0, 32'h20,  32'h0, 1'b1, 32'h8001_1234);
    issue(1'b0, 2'b10, 1'b0, 32'h00,  32'h0, 1'b1, 32'h0000_0000);
    idle();

    // Back-to-back requests, with req_valid held for 4 cycles
    p0 = pulses;
    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b1, 32'h0000_0000);
    issue(1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFE_F00D);
    idle(3);
    check("b2b_pulses", pulses - p0, 32'd4);

    // Randomized traffic checked against the model
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) idle();
      sz = 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 15) == 0) sz = 2'b11;
      if ($urandom_range(0, 15) == 0) a = $urandom() | 32'h100;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
    end
    idle(3);

    // Reset while a load response is still in flight: the response is dropped
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    req_valid = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    #1 check_reset_outputs("midreq");
    @(negedge clk); check_reset_outputs("midreq2");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    sweep_count("midreq", 1'b0);

    // Reset partway through the sweep restarts it from index 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midsweep_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1 check_reset_outputs("midsweep");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    sweep_count("midsweep", 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1, 32'h0000_0000);
    issue(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 1'b1, 32'h0000_0000);
    idle(3);

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit, so the run always terminates
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
Parametrised data memory for the single-cycle/multi-cycle CPU datapath. It supersedes the fixed 64-word word-only memory with:
- configurable depth
- byte, half and word loads/stores with sign/zero extension
- alignment and range fault detection
- a valid/ready request port with a registered response
- a post-reset hardware clear sweep, so the array needs no asynchronous reset.

The block sits between the EX/MEM stage and the MEM/WB register.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, minimum 2. IDX_W = clog2(DEPTH).
CLEAR_ON_RESET, 1, 1 = sweep array to zero after reset; 0 = array contents undefined after reset, go straight to IDLE.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores/word
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle pulse, response for accepted request
rsp_rdata  out  32  load result, extended; 0 for stores and faults
rsp_fault  out  1  request faulted (valid with rsp_valid)
busy  out  1  clear sweep in progress

Behaviour:
- Reset (async, any time):
  - state = CLEAR if CLEAR_ON_RESET else IDLE.
  - clr_idx = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0.
  - Any in-flight response is dropped.
  - Reset during a sweep restarts the sweep at index 0.
- State CLEAR:
  - busy = 1, req_ready = 0.
  - Each clk edge writes 0 to mem[clr_idx], then clr_idx++.
  - After the edge that writes index DEPTH-1, go to IDLE. The sweep takes exactly DEPTH cycles.
  - req_valid is ignored and no responses are produced.
- State IDLE:
  - busy = 0, req_ready = 1.
  - A request is accepted on the clk edge where req_valid && req_ready.
  - One request can be accepted per cycle with no bubbles.
- Latency:
  - The response appears on the edge after acceptance. rsp_valid is high for exactly one cycle per accepted request and is low otherwise.
  - There is no response backpressure.
- Addressing:
  - idx = req_addr[IDX_W+1:2]. Lane = req_addr[1:0]; little-endian, byte k = bits [8k+7:8k].
  - Half uses bits [16*req_addr[1]+15 : 16*req_addr[1]].
- Fault when any of the following holds:
  - req_size == 11
  - half with req_addr[0] = 1
  - word with req_addr[1:0] != 0
  - req_addr[31:IDX_W+2] != 0 (out of range)
- On a fault: no array write, rsp_fault = 1, rsp_rdata = 0.
- Store (no fault):
  - On the accept edge, write only the selected byte/half/word lanes with the low bits of req_wdata. Other lanes are unchanged.
  - Response: rsp_fault = 0, rsp_rdata = 0.
- Load (no fault):
  - The response edge registers the selected lane.
  - The result is sign-extended from bit 7/15, or zero-extended if req_unsigned. Word loads are passed through.
- Ordering:
  - A store accepted in cycle N followed by a load to the same word in cycle N+1 returns the new data.
  - The array read happens at the response edge, after the store committed.
- Simultaneous: reset wins over any request.

Test Plan:
- Assert rst 2 cycles, CLEAR_ON_RESET=1, DEPTH=64 -> busy=1 and req_ready=0 for exactly 64 cycles after release; then word loads of addr 0x00 and 0xFC return 0x00000000.
- Store word 0x11223344 @0x10, then store byte 0xAA @0x12 -> word load @0x10 = 0x11AA3344; byte load @0x12 signed = 0xFFFFFFAA, unsigned = 0x000000AA.
- Store half 0x8001 @0x22 -> half load @0x22 signed = 0xFFFF8001, unsigned = 0x00008001; word load @0x20 = 0x8001xxxx with the low half preserved.
- Faults: word @0x13, half @0x21, size 11, word @0x100 with DEPTH=64 -> each rsp_fault=1 and rsp_rdata=0; a word load afterward shows the target words unchanged.
- Back-to-back: req_valid held 4 cycles (store 0xDEADBEEF @0x8, load @0x8, load @0x4, store @0xC) -> 4 consecutive rsp_valid pulses, second returns 0xDEADBEEF.
- Reset asserted mid-sweep (cycle 30) and mid-request -> no rsp_valid; after release the full 64-cycle sweep restarts; outputs stay at 0 throughout reset.
